decode_cycle: RTL and testbench

- Second stage of the 5-stage RV32I pipeline.
- Sits directly downstream of the fetch stage: consumes InstrD, PCD and PCPlus4D, and feeds the execute stage.
- Contains the main/ALU control decoder, the immediate extender and the 32x32 register file.
- Writeback stage drives the register-file write port.
- The ID/EX pipeline register is clocked here and presents all execute-stage operands and controls.

---
 rtl/decode_pkg.sv | 69 ++++++
 rtl/decode_cycle_reg_file.sv | 41 ++++
 rtl/decode_cycle.sv | 184 ++++++++++++++++++
 tb/tb_decode_cycle.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, ALU codes, immediate formats and ID/EX record for decode_cycle
package decode_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Coarse ALU intent from the main decoder; funct3 is only consulted for ALU-class ops.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic                reg_write;
        logic [1:0]          result_src;
        logic                mem_write;
        logic                jump;
        logic                branch;
        logic [2:0]          alu_control;
        logic                alu_src;
        logic [DATA_W-1:0]   rd1;
        logic [DATA_W-1:0]   rd2;
        logic [DATA_W-1:0]   imm_ext;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [REG_AW-1:0]   rd;
        logic [DATA_W-1:0]   pc;
        logic [DATA_W-1:0]   pc_plus4;
    } idex_t;

    function automatic logic [DATA_W-1:0] imm_extend(input logic [31:0] instr, input imm_src_e src);
        logic [DATA_W-1:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// rtl/decode_cycle_reg_file.sv - register file with async clear, hardwired x0 and write-through reads
module reg_file
    import decode_pkg::*;
#(
    parameter int XLEN  = DATA_W,
    parameter int NREGS = NUM_REGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Writeback in the same cycle is forwarded so decode never sees a stale value.
    assign rdata1_o = (raddr1_i == '0)                  ? '0      :
                      (wr_en && (waddr_i == raddr1_i))  ? wdata_i : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0)                  ? '0      :
                      (wr_en && (waddr_i == raddr2_i))  ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage and ID/EX register; DECODE_FLUSH_EN adds the FlushE input
module decode_cycle
    import decode_pkg::*;
#(
    parameter int XLEN  = DATA_W,
    parameter int NREGS = NUM_REGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          InstrD,
    input  logic [XLEN-1:0]          PCD,
    input  logic [XLEN-1:0]          PCPlus4D,
    input  logic                     RegWriteW,
    input  logic [$clog2(NREGS)-1:0] RDW,
    input  logic [XLEN-1:0]          ResultW,
`ifdef DECODE_FLUSH_EN
    input  logic                     FlushE,
`endif
    output logic                     RegWriteE,
    output logic [1:0]               ResultSrcE,
    output logic                     MemWriteE,
    output logic                     JumpE,
    output logic                     BranchE,
    output logic [2:0]               ALUControlE,
    output logic                     ALUSrcE,
    output logic [XLEN-1:0]          RD1E,
    output logic [XLEN-1:0]          RD2E,
    output logic [XLEN-1:0]          ImmExtE,
    output logic [$clog2(NREGS)-1:0] RS1E,
    output logic [$clog2(NREGS)-1:0] RS2E,
    output logic [$clog2(NREGS)-1:0] RDE,
    output logic [XLEN-1:0]          PCE,
    output logic [XLEN-1:0]          PCPlus4E
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    imm_src_e        imm_src;
    alu_op_e         alu_op;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    idex_t           idex_d;
    idex_t           idex_q;
    idex_t           idex_vis;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];

    always_comb begin
        reg_write  = 1'b0;
        result_src = RES_ALU;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (opcode)
            OP_LOAD: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                alu_src    = 1'b1;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_ITYPE: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                imm_src = IMM_B;
                alu_op  = ALUOP_SUB;
            end
            OP_JAL: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
            end
            default: ;
        endcase
    end

    // Only R-type with funct7[5] set turns funct3=000 into a subtract; addi never does.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = ({InstrD[5], InstrD[30]} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:     alu_control = ALU_ADD;
        endcase
    end

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst),
        .we_i     (RegWriteW),
        .waddr_i  (RDW),
        .wdata_i  (ResultW),
        .raddr1_i (InstrD[19:15]),
        .raddr2_i (InstrD[24:20]),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    always_comb begin
        idex_d             = '0;
        idex_d.reg_write   = reg_write;
        idex_d.result_src  = result_src;
        idex_d.mem_write   = mem_write;
        idex_d.jump        = jump;
        idex_d.branch      = branch;
        idex_d.alu_control = alu_control;
        idex_d.alu_src     = alu_src;
        idex_d.rd1         = rd1;
        idex_d.rd2         = rd2;
        idex_d.imm_ext     = imm_extend(InstrD, imm_src);
        idex_d.rs1         = InstrD[19:15];
        idex_d.rs2         = InstrD[24:20];
        idex_d.rd          = InstrD[11:7];
        idex_d.pc          = PCD;
        idex_d.pc_plus4    = PCPlus4D;
`ifdef DECODE_FLUSH_EN
        if (FlushE) begin
            idex_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // Gate outputs while rst is held so execute sees zeros even between edges.
    assign idex_vis = rst ? idex_q : '0;

    assign RegWriteE   = idex_vis.reg_write;
    assign ResultSrcE  = idex_vis.result_src;
    assign MemWriteE   = idex_vis.mem_write;
    assign JumpE       = idex_vis.jump;
    assign BranchE     = idex_vis.branch;
    assign ALUControlE = idex_vis.alu_control;
    assign ALUSrcE     = idex_vis.alu_src;
    assign RD1E        = idex_vis.rd1;
    assign RD2E        = idex_vis.rd2;
    assign ImmExtE     = idex_vis.imm_ext;
    assign RS1E        = idex_vis.rs1;
    assign RS2E        = idex_vis.rs2;
    assign RDE         = idex_vis.rd;
    assign PCE         = idex_vis.pc;
    assign PCPlus4E    = idex_vis.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - scoreboard bench for decode_cycle
module tb_decode_cycle;

    typedef struct packed {
        logic        regw;
        logic [1:0]  rsrc;
        logic        memw;
        logic        jump;
        logic        branch;
        logic [2:0]  aluc;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW;
    logic [4:0]  RDW;
`ifdef DECODE_FLUSH_EN
    logic        FlushE;
`endif
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RS1E, RS2E, RDE;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
`ifdef DECODE_FLUSH_EN
        .FlushE      (FlushE),
`endif
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .RS1E        (RS1E),
        .RS2E        (RS2E),
        .RDE         (RDE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic regw, input logic [1:0] rsrc, input logic memw,
                                input logic jump, input logic branch, input logic [2:0] aluc,
                                input logic alusrc, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd);
        exp_t e;
        e = '0;
        e.regw = regw; e.rsrc = rsrc; e.memw = memw; e.jump = jump; e.branch = branch;
        e.aluc = aluc; e.alusrc = alusrc; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        return e;
    endfunction

    task automatic compare_outputs(input string tag, input exp_t e);
        check_eq({tag, ".RegWriteE"},   {31'd0, RegWriteE},   {31'd0, e.regw});
        check_eq({tag, ".ResultSrcE"},  {30'd0, ResultSrcE},  {30'd0, e.rsrc});
        check_eq({tag, ".MemWriteE"},   {31'd0, MemWriteE},   {31'd0, e.memw});
        check_eq({tag, ".JumpE"},       {31'd0, JumpE},       {31'd0, e.jump});
        check_eq({tag, ".BranchE"},     {31'd0, BranchE},     {31'd0, e.branch});
        check_eq({tag, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, e.aluc});
        check_eq({tag, ".ALUSrcE"},     {31'd0, ALUSrcE},     {31'd0, e.alusrc});
        check_eq({tag, ".RD1E"},        RD1E,                 e.rd1);
        check_eq({tag, ".RD2E"},        RD2E,                 e.rd2);
        check_eq({tag, ".ImmExtE"},     ImmExtE,              e.imm);
        check_eq({tag, ".RS1E"},        {27'd0, RS1E},        {27'd0, e.rs1});
        check_eq({tag, ".RS2E"},        {27'd0, RS2E},        {27'd0, e.rs2});
        check_eq({tag, ".RDE"},         {27'd0, RDE},         {27'd0, e.rd});
        check_eq({tag, ".PCE"},         PCE,                  e.pc);
        check_eq({tag, ".PCPlus4E"},    PCPlus4E,             e.pc4);
    endtask

    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                        input logic flush, input exp_t e);
        exp_t got;
        @(negedge clk);
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        RegWriteW = wb_en;
        RDW       = wb_rd;
        ResultW   = wb_data;
`ifdef DECODE_FLUSH_EN
        FlushE    = flush;
`endif
        if (flush) begin
            e.pc  = '0;
            e.pc4 = '0;
        end else begin
            e.pc  = pc;
            e.pc4 = pc + 32'd4;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        RegWriteW = 1'b0;
        got = exp_q.pop_front();
        compare_outputs(tag, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t dummy;
        rst = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
        RegWriteW = 1'b0; RDW = '0; ResultW = '0;
`ifdef DECODE_FLUSH_EN
        FlushE = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        compare_outputs("reset", '0);
        @(negedge clk);
        rst = 1'b1;

        step("bubble_wb_x1", 32'h0000_0000, 32'h0, 1'b1, 5'd1, 32'd5, 1'b0,
             mk(0, 2'b00, 0, 0, 0, 3'b000, 0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0));
        step("addi", 32'h0050_0093, 32'h4, 1'b1, 5'd2, 32'd7, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b000, 1, 32'd0, 32'd0, 32'd5, 5'd0, 5'd5, 5'd1));
        step("lw", 32'h0080_A103, 32'h8, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1, 2'b01, 0, 0, 0, 3'b000, 1, 32'd5, 32'd0, 32'd8, 5'd1, 5'd8, 5'd2));
        step("sw", 32'h0020_A623, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(0, 2'b00, 1, 0, 0, 3'b000, 1, 32'd5, 32'd7, 32'd12, 5'd1, 5'd2, 5'd12));
        step("beq", 32'hFE20_8CE3, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(0, 2'b00, 0, 0, 1, 3'b001, 0, 32'd5, 32'd7, 32'hFFFF_FFF8, 5'd1, 5'd2, 5'd25));
        step("wthru_x3", 32'h0001_8233, 32'h14, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b000, 0, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd3, 5'd0, 5'd4));
        step("wthru_x0", 32'h0000_0233, 32'h18, 1'b1, 5'd0, 32'h1234_5678, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b000, 0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4));
        step("sub", 32'h4011_82B3, 32'h1C, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b001, 0, 32'hDEAD_BEEF, 32'd5, 32'h401, 5'd3, 5'd1, 5'd5));
        step("jal", 32'h0100_00EF, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1, 2'b10, 0, 1, 0, 3'b000, 0, 32'd0, 32'd0, 32'd16, 5'd0, 5'd16, 5'd1));
        step("or", 32'h0020_E333, 32'h24, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b011, 0, 32'd5, 32'd7, 32'd2, 5'd1, 5'd2, 5'd6));
        step("andi", 32'hFFF0_F393, 32'h28, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b010, 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'd1, 5'd31, 5'd7));
        step("slti", 32'h0030_A413, 32'h2C, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b101, 1, 32'd5, 32'hDEAD_BEEF, 32'd3, 5'd1, 5'd3, 5'd8));
        step("bad_op", 32'h0000_007F, 32'h30, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(0, 2'b00, 0, 0, 0, 3'b000, 0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0));
`ifdef DECODE_FLUSH_EN
        step("flush_addi", 32'h0050_0093, 32'h34, 1'b0, 5'd0, 32'd0, 1'b1, '0);
`endif

        step("pre_rst_addi", 32'h0050_0093, 32'h40, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b000, 1, 32'd0, 32'd0, 32'd5, 5'd0, 5'd5, 5'd1));
        #1;
        rst = 1'b0;
        #1;
        dummy = '0;
        compare_outputs("reset_mid", dummy);
        @(negedge clk);
        rst = 1'b1;
        step("post_rst_x3", 32'h0001_8233, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b000, 0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd0, 5'd4));
        step("post_rst_sub", 32'h4011_82B3, 32'h48, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1, 2'b00, 0, 0, 0, 3'b001, 0, 32'd0, 32'd0, 32'h401, 5'd3, 5'd1, 5'd5));

        check_eq("sb_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
